// File: rtl/ikaopm_timerreg.sv
// Timer register block: synchronised CPU write port, phi1-aligned commit of timer registers, busy status.
// Optional define IKAOPM_TIMERREG_TEST_EN maps address 0x01 onto o_TEST_D2.
module ikaopm_timerreg (
    input  logic       i_EMUCLK,
    input  logic       i_MRST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic [7:0] o_D,
    output logic       o_D_OE,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_CSM_EN,
    output logic       o_TEST_D2
);

    logic       cs_s1, cs_s2, wr_s1, wr_s2, rd_s1, rd_s2, a0_s1, a0_s2;
    logic [7:0] d_s1, d_s2;
    logic [1:0] rdy;
    logic       wr_prev;
    logic       wr_act, wr_evt, ncen, commit;

    logic [7:0] addr_reg;
    logic       pending;
    logic [7:0] pend_addr, pend_data;
    logic       busy;
    logic [5:0] busy_cnt;

    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            wr_s1   <= 1'b0;
            wr_s2   <= 1'b0;
            rd_s1   <= 1'b0;
            rd_s2   <= 1'b0;
            a0_s1   <= 1'b0;
            a0_s2   <= 1'b0;
            d_s1    <= '0;
            d_s2    <= '0;
            rdy     <= '0;
            wr_prev <= 1'b0;
        end else begin
            cs_s1   <= i_CS_n;
            cs_s2   <= cs_s1;
            wr_s1   <= i_WR_n;
            wr_s2   <= wr_s1;
            rd_s1   <= i_RD_n;
            rd_s2   <= rd_s1;
            a0_s1   <= i_A0;
            a0_s2   <= a0_s1;
            d_s1    <= i_D;
            d_s2    <= d_s1;
            rdy     <= {rdy[0], 1'b1};
            wr_prev <= wr_act;
        end
    end

    // Reset clears the synchronisers to "active" levels; rdy masks bus events until they refill.
    assign wr_act = ~cs_s2 & ~wr_s2;
    assign wr_evt = rdy[1] & wr_act & ~wr_prev;
    assign ncen   = ~i_phi1_NCEN_n;
    assign commit = pending & ncen;
    assign o_D_OE = rdy[1] & ~cs_s2 & ~rd_s2;

    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            addr_reg        <= '0;
            pending         <= 1'b0;
            pend_addr       <= '0;
            pend_data       <= '0;
            busy            <= 1'b0;
            busy_cnt        <= '0;
            o_D             <= '0;
            o_CLKA1         <= '0;
            o_CLKA2         <= '0;
            o_CLKB          <= '0;
            o_TIMERA_RUN    <= 1'b0;
            o_TIMERB_RUN    <= 1'b0;
            o_TIMERA_IRQ_EN <= 1'b0;
            o_TIMERB_IRQ_EN <= 1'b0;
            o_TIMERA_FRST   <= 1'b0;
            o_TIMERB_FRST   <= 1'b0;
            o_CSM_EN        <= 1'b0;
        end else begin
            if (wr_evt && !a0_s2) addr_reg <= d_s2;
            if (wr_evt && a0_s2) begin
                pend_addr <= addr_reg;
                pend_data <= d_s2;
            end
            // A write landing on the commit edge becomes the next pending entry.
            pending <= (wr_evt & a0_s2) | (pending & ~ncen);

            if (ncen) begin
                o_TIMERA_FRST <= commit & pend_data[4];
                o_TIMERB_FRST <= commit & pend_data[5];
            end

            if (commit) begin
                case (pend_addr)
                    8'h10: o_CLKA1 <= pend_data;
                    8'h11: o_CLKA2 <= pend_data[1:0];
                    8'h12: o_CLKB  <= pend_data;
                    8'h14: begin
                        o_CSM_EN        <= pend_data[7];
                        o_TIMERB_IRQ_EN <= pend_data[3];
                        o_TIMERA_IRQ_EN <= pend_data[2];
                        o_TIMERB_RUN    <= pend_data[1];
                        o_TIMERA_RUN    <= pend_data[0];
                    end
                    default: ;
                endcase
                busy     <= 1'b1;
                busy_cnt <= '1;
            end else if (ncen && busy) begin
                if (busy_cnt == 6'd0) busy <= 1'b0;
                else                  busy_cnt <= busy_cnt - 6'd1;
            end

            o_D <= {busy, 5'b0, i_TIMERB_FLAG, i_TIMERA_FLAG};
        end
    end

`ifdef IKAOPM_TIMERREG_TEST_EN
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST)                             o_TEST_D2 <= 1'b0;
        else if (commit && pend_addr == 8'h01)  o_TEST_D2 <= pend_data[2];
    end
`else
    assign o_TEST_D2 = 1'b0;
`endif

endmodule

// File: tb/tb_ikaopm_timerreg.sv
// Self-checking bench for ikaopm_timerreg: edge-level reference model, register table, directed corner sequences.
module tb_ikaopm_timerreg;

    logic       clk = 1'b0, mrst = 1'b1, ncen_n = 1'b1;
    logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
    logic [7:0] d = '0;
    logic       fa = 1'b0, fb = 1'b0;
    logic [7:0] o_D, o_CLKA1, o_CLKB;
    logic [1:0] o_CLKA2;
    logic       o_D_OE, o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN;
    logic       o_TIMERA_FRST, o_TIMERB_FRST, o_CSM_EN, o_TEST_D2;

    ikaopm_timerreg dut (
        .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen_n),
        .i_CS_n(cs_n), .i_WR_n(wr_n), .i_RD_n(rd_n), .i_A0(a0), .i_D(d),
        .o_D(o_D), .o_D_OE(o_D_OE),
        .i_TIMERA_FLAG(fa), .i_TIMERB_FLAG(fb),
        .o_CLKA1(o_CLKA1), .o_CLKA2(o_CLKA2), .o_CLKB(o_CLKB),
        .o_TIMERA_RUN(o_TIMERA_RUN), .o_TIMERB_RUN(o_TIMERB_RUN),
        .o_TIMERA_IRQ_EN(o_TIMERA_IRQ_EN), .o_TIMERB_IRQ_EN(o_TIMERB_IRQ_EN),
        .o_TIMERA_FRST(o_TIMERA_FRST), .o_TIMERB_FRST(o_TIMERB_FRST),
        .o_CSM_EN(o_CSM_EN), .o_TEST_D2(o_TEST_D2)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int ncen_mode = 0;
    bit last_ncen = 0;
    bit rand_flags = 0;

`ifdef IKAOPM_TIMERREG_TEST_EN
    localparam bit TEST_EN = 1'b1;
`else
    localparam bit TEST_EN = 1'b0;
`endif

    // Reference model: register file, one-slot pending write, busy as "NCEN edges remaining".
    logic [7:0] m_addr, m_pa, m_pd, m_clka1, m_clkb, m_od;
    logic [1:0] m_clka2;
    bit m_pv, m_runa, m_runb, m_irqa, m_irqb, m_csm, m_test, m_frsta, m_frstb, m_oe;
    int m_busy_rem, m_edges;
    bit h_cs[3], h_wr[3], h_rd[3], h_a0[3];
    logic [7:0] h_d[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_pa = 0; m_pd = 0; m_clka1 = 0; m_clka2 = 0; m_clkb = 0; m_od = 0;
        m_pv = 0; m_runa = 0; m_runb = 0; m_irqa = 0; m_irqb = 0; m_csm = 0; m_test = 0;
        m_frsta = 0; m_frstb = 0; m_oe = 0; m_busy_rem = 0; m_edges = 0;
        for (int i = 0; i < 3; i++) begin
            h_cs[i] = 1; h_wr[i] = 1; h_rd[i] = 1; h_a0[i] = 0; h_d[i] = 0;
        end
    endtask

    task automatic model_step();
        bit bp, ev;
        if (mrst) begin
            model_reset();
            return;
        end
        bp = (m_busy_rem > 0);
        // A strobe first sampled at edge k acts at edge k+2 (two sync flops, then edge detect).
        ev = (m_edges >= 2) && !h_cs[1] && !h_wr[1] && !(!h_cs[2] && !h_wr[2]);
        if (!ncen_n) begin
            if (m_pv) begin
                case (m_pa)
                    8'h10: m_clka1 = m_pd;
                    8'h11: m_clka2 = m_pd[1:0];
                    8'h12: m_clkb = m_pd;
                    8'h14: begin
                        m_csm = m_pd[7]; m_irqb = m_pd[3]; m_irqa = m_pd[2];
                        m_runb = m_pd[1]; m_runa = m_pd[0];
                    end
                    8'h01: if (TEST_EN) m_test = m_pd[2];
                    default: ;
                endcase
                m_frsta = m_pd[4];
                m_frstb = m_pd[5];
                m_busy_rem = 64;
                m_pv = 0;
            end else begin
                m_frsta = 0;
                m_frstb = 0;
                if (m_busy_rem > 0) m_busy_rem--;
            end
        end
        if (ev) begin
            if (!h_a0[1]) m_addr = h_d[1];
            else begin
                m_pv = 1; m_pa = m_addr; m_pd = h_d[1];
            end
        end
        m_od = {bp, 5'b0, fb, fa};
        m_oe = (m_edges >= 1) && !h_cs[0] && !h_rd[0];
        for (int i = 2; i > 0; i--) begin
            h_cs[i] = h_cs[i-1]; h_wr[i] = h_wr[i-1]; h_rd[i] = h_rd[i-1];
            h_a0[i] = h_a0[i-1]; h_d[i] = h_d[i-1];
        end
        h_cs[0] = cs_n; h_wr[0] = wr_n; h_rd[0] = rd_n; h_a0[0] = a0; h_d[0] = d;
        m_edges++;
    endtask

    task automatic compare();
        chk("clk_regs", 32'({o_CLKA1, o_CLKA2, o_CLKB}), 32'({m_clka1, m_clka2, m_clkb}));
        chk("ctrl", 32'({o_CSM_EN, o_TIMERB_IRQ_EN, o_TIMERA_IRQ_EN, o_TIMERB_RUN, o_TIMERA_RUN, o_TEST_D2}),
            32'({m_csm, m_irqb, m_irqa, m_runb, m_runa, m_test}));
        chk("frst", 32'({o_TIMERB_FRST, o_TIMERA_FRST}), 32'({m_frstb, m_frsta}));
        chk("status", 32'({o_D_OE, o_D}), 32'({m_oe, m_od}));
    endtask

    task automatic tick();
        case (ncen_mode)
            0:       ncen_n = (cyc % 4 != 0);
            1:       ncen_n = 1'b1;
            default: ncen_n = ($urandom_range(3) != 0);
        endcase
        if (rand_flags) begin
            fa = 1'($urandom_range(1));
            fb = 1'($urandom_range(1));
        end
        last_ncen = !ncen_n;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        cyc++;
    endtask

    task automatic bus_wr(input bit ia0, input logic [7:0] id);
        cs_n = 0; wr_n = 0; a0 = ia0; d = id;
        tick(); tick();
        cs_n = 1; wr_n = 1;
        tick(); tick();
    endtask

    task automatic write_reg(input logic [7:0] ad, input logic [7:0] dd);
        bus_wr(0, ad);
        bus_wr(1, dd);
    endtask

    task automatic do_reset();
        mrst = 1; cs_n = 1; wr_n = 1; rd_n = 1;
        model_reset();
        #1;
        compare();
        tick(); tick();
        mrst = 0;
        tick(); tick(); tick();
    endtask

    // NCEN edges from the tick after a commit until the status busy bit reads 0.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (last_ncen) n++;
            if (!o_D[7]) break;
        end
    endtask

    task automatic wait_clka1(input logic [7:0] v);
        int i;
        for (i = 0; i < 100 && o_CLKA1 != v; i++) tick();
        chk("wait_clka1", 32'(o_CLKA1), 32'(v));
    endtask

    function automatic logic [7:0] get_field(input int sel);
        case (sel)
            0:       return o_CLKA1;
            1:       return {6'b0, o_CLKA2};
            2:       return o_CLKB;
            3:       return {3'b0, o_CSM_EN, o_TIMERB_IRQ_EN, o_TIMERA_IRQ_EN, o_TIMERB_RUN, o_TIMERA_RUN};
            default: return {7'b0, o_TEST_D2};
        endcase
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] dat;
        int         sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[7];
    logic [7:0] addrs[6];

    initial begin
        int n, seen;
        bit saw1;
        logic [7:0] ra, rdat;

        vt[0] = '{8'h10, 8'hA5, 0, 8'hA5};
        vt[1] = '{8'h11, 8'hFF, 1, 8'h03};
        vt[2] = '{8'h12, 8'h3C, 2, 8'h3C};
        vt[3] = '{8'h14, 8'h8D, 3, 8'h1D};
        vt[4] = '{8'h13, 8'hFF, 0, 8'hA5};
        vt[5] = '{8'h14, 8'h00, 3, 8'h00};
        vt[6] = '{8'h01, 8'h04, 4, {7'b0, TEST_EN}};
        addrs = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h01, 8'h33};

        model_reset();
        @(negedge clk);
        chk("reset_outputs", 32'({o_CLKA1, o_CLKA2, o_CLKB, o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN,
            o_TIMERB_IRQ_EN, o_TIMERA_FRST, o_TIMERB_FRST, o_CSM_EN, o_TEST_D2}), 32'h0);
        chk("reset_status", 32'({o_D_OE, o_D}), 32'h0);
        do_reset();

        // Register map table.
        for (int i = 0; i < 7; i++) begin
            write_reg(vt[i].a, vt[i].dat);
            for (int k = 0; k < 8; k++) tick();
            chk($sformatf("table[%0d]", i), 32'(get_field(vt[i].sel)), 32'(vt[i].exp));
        end

        // CLKA1 write and busy length.
        do_reset();
        write_reg(8'h10, 8'hA5);
        wait_clka1(8'hA5);
        count_busy(n);
        chk("busy_len_a1", n, 64);

        // Control write with one-shot FRST.
        do_reset();
        write_reg(8'h14, 8'h3F);
        for (int i = 0; i < 100 && !o_TIMERA_RUN; i++) tick();
        chk("ctrl_3f", 32'({o_CSM_EN, o_TIMERB_IRQ_EN, o_TIMERA_IRQ_EN, o_TIMERB_RUN, o_TIMERA_RUN}), 32'h0F);
        chk("frst_on", 32'({o_TIMERB_FRST, o_TIMERA_FRST}), 32'h3);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            saw1 = o_TIMERA_FRST && o_TIMERB_FRST;
            tick();
            if (last_ncen && saw1) seen++;
        end
        chk("frst_edges", seen, 1);
        chk("frst_off", 32'({o_TIMERB_FRST, o_TIMERA_FRST}), 32'h0);

        // Commit while busy extends busy.
        do_reset();
        write_reg(8'h12, 8'h11);
        for (int i = 0; i < 100 && o_CLKB != 8'h11; i++) tick();
        n = 0;
        for (int i = 0; i < 200 && n < 20; i++) begin
            tick();
            if (last_ncen) n++;
        end
        bus_wr(1, 8'h22);
        for (int i = 0; i < 100 && o_CLKB != 8'h22; i++) tick();
        chk("clkb_second", 32'(o_CLKB), 32'h22);
        count_busy(n);
        chk("busy_len_ext", n, 64);

        // Two data writes before any NCEN edge: last wins, single commit.
        do_reset();
        ncen_mode = 1;
        bus_wr(0, 8'h11);
        bus_wr(1, 8'h01);
        bus_wr(1, 8'h03);
        chk("clka2_held", 32'(o_CLKA2), 32'h0);
        ncen_mode = 0;
        saw1 = 0;
        for (int i = 0; i < 100 && o_CLKA2 != 2'd3; i++) begin
            tick();
            if (o_CLKA2 == 2'd1) saw1 = 1;
        end
        chk("clka2_last", 32'(o_CLKA2), 32'h3);
        chk("clka2_no_first", 32'(saw1), 32'h0);
        count_busy(n);
        chk("busy_len_single", n, 64);

        // Pending entry keeps its address when the address register changes afterwards.
        do_reset();
        ncen_mode = 1;
        write_reg(8'h10, 8'h33);
        bus_wr(0, 8'h12);
        ncen_mode = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("pend_addr_kept", 32'({o_CLKA1, o_CLKB}), 32'h3300);

        // Reset with busy and a pending write; then status read.
        do_reset();
        write_reg(8'h12, 8'h77);
        for (int i = 0; i < 100 && o_CLKB != 8'h77; i++) tick();
        ncen_mode = 1;
        write_reg(8'h10, 8'h5A);
        do_reset();
        chk("rst_outputs", 32'({o_CLKA1, o_CLKA2, o_CLKB, o_D}), 32'h0);
        ncen_mode = 0;
        for (int i = 0; i < 300; i++) tick();
        chk("rst_no_commit", 32'(o_CLKA1), 32'h0);
        fa = 1; fb = 0;
        cs_n = 0; rd_n = 0;
        tick(); tick(); tick();
        chk("status_read", 32'({o_D_OE, o_D}), 32'h101);
        cs_n = 1; rd_n = 1;
        tick(); tick(); tick();

        // Test register.
        write_reg(8'h01, 8'h04);
        for (int i = 0; i < 8; i++) tick();
        chk("test_d2", 32'(o_TEST_D2), 32'(TEST_EN));

        // Randomised traffic against the model.
        rand_flags = 1;
        ncen_mode = 2;
        for (int i = 0; i < 250; i++) begin
            ra = addrs[$urandom_range(5)];
            rdat = 8'($urandom);
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: write_reg(ra, rdat);
                6: bus_wr(1, rdat);
                7: bus_wr(0, ra);
                8: begin
                    cs_n = 0; rd_n = 0;
                    tick(); tick();
                    cs_n = 1; rd_n = 1;
                    tick();
                end
                default: for (int k = 0; k < int'($urandom_range(5)) + 1; k++) tick();
            endcase
        end
        rand_flags = 0;
        for (int i = 0; i < 10; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
